// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh router output stage: port count,
// port index names, arbiter states and the modulo-step helper.
package mesh_pkg;

  localparam int N_PORTS = 5;

  typedef enum logic [2:0] {
    NORTH = 3'd0,
    EAST  = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } arb_state_e;

  // Index base+offset folded into 0..n-1; callers keep base < n and offset < n.
  function automatic int rr_index(input int base, input int offset, input int n);
    int sum;
    sum = base + offset;
    return (sum >= n) ? sum - n : sum;
  endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Rotating-priority search: picks the first requesting port at or after
// ptr_i, wrapping modulo N_PORTS.
module rr_priority_encoder #(
  parameter int N_PORTS = mesh_pkg::N_PORTS,
  parameter int PTR_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [N_PORTS-1:0] grant_o,
  output logic               valid_o,
  output logic [PTR_W-1:0]   winner_o
);
  import mesh_pkg::*;

  logic [PTR_W-1:0] cand;

  always_comb begin
    grant_o  = '0;
    valid_o  = 1'b0;
    winner_o = '0;
    cand     = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      cand = PTR_W'(rr_index(int'(ptr_i), k, N_PORTS));
      if (!valid_o && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        valid_o       = 1'b1;
        winner_o      = cand;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Output port arbiter: round-robin grant across input FIFOs into a
// one-deep output register that honours downstream hold.
//
//   state | meaning
//   IDLE  | output register empty; always accepts
//   SEND  | register full, last seen with holdIn low; accepts when holdIn low
//   STALL | register full, downstream holding; flit and rrPtr frozen
module output_port_arbiter #(
  parameter int FIFO_WIDTH = 64,
  parameter int N_PORTS    = mesh_pkg::N_PORTS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_PORTS-1:0]    requestValid,
  input  logic [FIFO_WIDTH-1:0] requestData [N_PORTS],
  output logic [N_PORTS-1:0]    requestPop,
  input  logic                  holdIn,
  output logic [FIFO_WIDTH-1:0] outData,
  output logic                  outWriteRequest
);
  import mesh_pkg::*;

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  arb_state_e            state_q, state_d;
  logic [FIFO_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_wr_q, out_wr_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic [N_PORTS-1:0]    grant;
  logic                  grant_valid;
  logic [PTR_W-1:0]      winner;
  logic                  accept;

  rr_priority_encoder #(
    .N_PORTS (N_PORTS),
    .PTR_W   (PTR_W)
  ) u_rr_priority_encoder (
    .req_i    (requestValid),
    .ptr_i    (rr_ptr_q),
    .grant_o  (grant),
    .valid_o  (grant_valid),
    .winner_o (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      out_data_q <= '0;
      out_wr_q   <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_wr_q   <= out_wr_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_wr_d   = out_wr_q;
    rr_ptr_d   = rr_ptr_q;
    requestPop = '0;
    accept     = 1'b0;

    // A full register frees up the same cycle holdIn drops, so SEND and
    // STALL share the accept rule.
    case (state_q)
      IDLE:        accept = 1'b1;
      SEND, STALL: accept = !holdIn;
      default:     accept = 1'b0;
    endcase

    if (accept) begin
      if (grant_valid) begin
        requestPop = grant;
        out_data_d = requestData[winner];
        out_wr_d   = 1'b1;
        rr_ptr_d   = (winner == PTR_W'(N_PORTS - 1)) ? '0 : winner + 1'b1;
        state_d    = holdIn ? STALL : SEND;
      end else begin
        out_wr_d = 1'b0;
        state_d  = IDLE;
      end
    end else begin
      state_d = STALL;
    end

    if (reset) begin
      requestPop = '0;
    end
  end

  assign outData         = out_data_q;
  assign outWriteRequest = out_wr_q;

endmodule

// File: doc/output_port_arbiter.md
OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 64, flit width in bits.
REQ-002 SHALL have parameter N_PORTS, default 5, number of requesting input ports; port index order N=0, E=1, S=2, W=3, LOCAL=4.
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have requestValid  input  N_PORTS  bit i high = input FIFO i holds a flit for this output.
REQ-006 SHALL have requestData  input  N_PORTS x FIFO_WIDTH (unpacked array)  head flit of each input FIFO.
REQ-007 SHALL have requestPop  output  N_PORTS  one-hot read strobe to the granted input FIFO.
REQ-008 SHALL have holdIn  input  1  downstream hold; high = downstream cannot accept a flit this cycle.
REQ-009 SHALL have outData  output  FIFO_WIDTH  registered flit to the downstream link.
REQ-010 SHALL have outWriteRequest  output  1  registered; high = outData valid this cycle.

Function
REQ-011 SHALL hold a one-deep output register (outData, outWriteRequest) and a round-robin pointer rrPtr (0..N_PORTS-1).
REQ-012 SHALL implement states IDLE (register empty), SEND (register full, holdIn low), STALL (register full, holdIn high).
REQ-013 SHALL define "accept" = register empty OR (register full AND holdIn low).
REQ-014 SHALL, on accept with any requestValid bit set, select the winner as the first valid port searching rrPtr, rrPtr+1, ... modulo N_PORTS.
REQ-015 SHALL assert requestPop[winner] combinationally in the accept cycle, with at most one bit high and never for a port whose requestValid is low.
REQ-016 SHALL load outData <= requestData[winner] and outWriteRequest <= 1 on the edge closing the accept cycle (latency: pop cycle N, flit on output cycle N+1).
REQ-017 SHALL, on accept with no valid request, clear outWriteRequest on the next edge; outData holds its previous value.
REQ-018 SHALL update rrPtr to (winner+1) modulo N_PORTS only on a grant; winner 4 wraps to 0; no grant leaves rrPtr unchanged.
REQ-019 SHALL, in STALL, keep outData/outWriteRequest stable, drive requestPop all-zero, and leave rrPtr unchanged.
REQ-020 SHALL permit a grant when holdIn is high but the register is empty (IDLE), filling the register; the next cycle is STALL if holdIn stays high.
REQ-021 SHALL sustain one flit per cycle back-to-back while holdIn stays low and requests remain.
REQ-022 SHALL treat a holdIn rise while in SEND as a transition to STALL that same cycle; the presented flit counts as not consumed.
REQ-023 SHALL guarantee that any continuously valid port is granted within N_PORTS accept cycles.
REQ-024 SHALL transition IDLE->SEND/STALL on a grant, SEND->SEND on a grant, SEND->IDLE on accept with no request, STALL->SEND when holdIn falls.

Reset
REQ-025 SHALL, when reset is high at a rising edge, set outWriteRequest=0, outData=0, rrPtr=0, state IDLE.
REQ-026 SHALL force requestPop to all-zero while reset is high, regardless of requests.
REQ-027 SHALL drop any flit held in the register when reset is asserted mid-STALL; that flit is not replayed.

Structure
REQ-028 SHALL take N_PORTS, the port-index enum (NORTH, EAST, SOUTH, WEST, LOCAL) and the state enum from shared package mesh_pkg.
REQ-029 SHALL place the rotating-priority search in one sub-module rr_priority_encoder (inputs: request vector, rrPtr; outputs: one-hot grant, grant valid, winner index).

Verification
REQ-030 SHALL check: reset held 2 cycles with requestValid=5'b11111 -> requestPop=0, outWriteRequest=0, outData=0 throughout.
REQ-031 SHALL check: after reset, requestValid=5'b11111 held, holdIn=0, data[i]=i+1 -> pops 0,1,2,3,4,0 on consecutive cycles; outData 1,2,3,4,5,1 one cycle later.
REQ-032 SHALL check: rrPtr=3, requestValid=5'b00101 -> winner port 0 (wrap), rrPtr becomes 1; next grant is port 2.
REQ-033 SHALL check: flit 0xA5 on output, holdIn high 3 cycles -> outData=0xA5 and outWriteRequest=1 stable, requestPop=0 for 3 cycles; pop resumes the cycle holdIn falls.
REQ-034 SHALL check: register empty, holdIn=1, requestValid=5'b10000 -> single pop of port 4, then STALL with no further pops until holdIn=0.
REQ-035 SHALL check: reset asserted during STALL -> next cycle outWriteRequest=0, rrPtr=0, held flit never appears at the output.
